// File: rtl/csr_access_unit.sv
// Zicsr initiator: sequences CSRRW/S/C (+ immediate forms) into read/write cycles toward the CSR file.
// Optional local read-only address check is enabled by defining CSR_ACCESS_RO_CHECK_EN.
module csr_access_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_funct3,
  input  logic [ADDR_W-1:0] op_csr_addr,
  input  logic [XLEN-1:0]   op_rs1_value,
  input  logic [4:0]        op_zimm,
  input  logic              op_rs1_is_x0,
  input  logic              op_rd_is_x0,
  output logic [ADDR_W-1:0] csr_num,
  output logic              read_csr,
  input  logic [XLEN-1:0]   read_value,
  output logic              write_csr,
  output logic [2:0]        write_function,
  output logic [XLEN-1:0]   write_value,
  input  logic              illegal_instr_exception,
  output logic              busy,
  output logic              done,
  output logic              rd_write,
  output logic [XLEN-1:0]   rd_value,
  output logic              exception
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [2:0]         funct3_r, funct3_s;
  logic [ADDR_W-1:0]  addr_r, addr_s;
  logic [XLEN-1:0]    src_r, src_s;
  logic [XLEN-1:0]    old_r, old_s;
  logic               rd_is_x0_r, rd_is_x0_s;
  logic               need_write_r, need_write_s;
  logic               exc_r, exc_s;

  logic               op_illegal_s;
  logic               op_need_read_s;
  logic               op_need_write_s;
  logic               op_ro_s;
  logic [XLEN-1:0]    op_src_s;

  logic               op_ready_s, busy_s, read_csr_s, write_csr_s;
  logic               done_s, rd_write_s, exception_s;
  logic [ADDR_W-1:0]  csr_num_s;
  logic [2:0]         write_function_s;
  logic [XLEN-1:0]    write_value_s, rd_value_s;

  // Read-modify-write: bitwise only, old is zero when no read was performed.
  function automatic logic [XLEN-1:0] rmw(input logic [2:0] f3,
                                          input logic [XLEN-1:0] old_v,
                                          input logic [XLEN-1:0] src_v);
    logic [XLEN-1:0] res;
    case (f3[1:0])
      2'b01:   res = src_v;
      2'b10:   res = old_v | src_v;
      2'b11:   res = old_v & ~src_v;
      default: res = {XLEN{1'b0}};
    endcase
    return res;
  endfunction

  // Decode of the presented op, used only on accept.
  always_comb begin
    op_illegal_s    = (op_funct3[1:0] == 2'b00);
    op_need_read_s  = (op_funct3[1:0] == 2'b10) || (op_funct3[1:0] == 2'b11) || !op_rd_is_x0;
    op_need_write_s = (op_funct3[1:0] == 2'b01) || !op_rs1_is_x0;
    if (op_funct3[2]) begin
      op_src_s = {{(XLEN-5){1'b0}}, op_zimm};
    end else begin
      op_src_s = op_rs1_value;
    end
`ifdef CSR_ACCESS_RO_CHECK_EN
    op_ro_s = op_need_write_s && (op_csr_addr[11:10] == 2'b11);
`else
    op_ro_s = 1'b0;
`endif
  end

  // Next-state and next-latch computation.
  always_comb begin
    state_s      = state_r;
    funct3_s     = funct3_r;
    addr_s       = addr_r;
    src_s        = src_r;
    old_s        = old_r;
    rd_is_x0_s   = rd_is_x0_r;
    need_write_s = need_write_r;
    exc_s        = exc_r;
    case (state_r)
      IDLE: begin
        if (op_valid) begin
          funct3_s     = op_funct3;
          addr_s       = op_csr_addr;
          src_s        = op_src_s;
          old_s        = {XLEN{1'b0}};
          rd_is_x0_s   = op_rd_is_x0;
          need_write_s = op_need_write_s && !op_ro_s;
          exc_s        = op_illegal_s || op_ro_s;
          if (op_illegal_s) begin
            state_s = DONE;
          end else if (op_need_read_s) begin
            state_s = READ;
          end else if (op_ro_s) begin
            state_s = DONE;
          end else begin
            state_s = WRITE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        old_s = read_value;
        exc_s = exc_r || illegal_instr_exception;
        if (exc_s) begin
          state_s = DONE;
        end else if (need_write_r) begin
          state_s = WRITE;
        end else begin
          state_s = DONE;
        end
      end
      WRITE: begin
        exc_s   = exc_r || illegal_instr_exception;
        state_s = DONE;
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output values for the next cycle, decoded from next state so outputs come straight from flops.
  always_comb begin
    op_ready_s       = (state_s == IDLE);
    busy_s           = (state_s != IDLE);
    read_csr_s       = (state_s == READ);
    write_csr_s      = (state_s == WRITE);
    done_s           = (state_s == DONE);
    csr_num_s        = {ADDR_W{1'b0}};
    write_function_s = 3'b000;
    write_value_s    = {XLEN{1'b0}};
    rd_write_s       = 1'b0;
    rd_value_s       = {XLEN{1'b0}};
    exception_s      = 1'b0;
    if (read_csr_s || write_csr_s) begin
      csr_num_s = addr_s;
    end else begin
      csr_num_s = {ADDR_W{1'b0}};
    end
    if (write_csr_s) begin
      write_function_s = funct3_s;
      write_value_s    = rmw(funct3_s, old_s, src_s);
    end else begin
      write_function_s = 3'b000;
      write_value_s    = {XLEN{1'b0}};
    end
    if (done_s) begin
      exception_s = exc_s;
      rd_write_s  = !exc_s && !rd_is_x0_s;
      rd_value_s  = old_s;
    end else begin
      exception_s = 1'b0;
      rd_write_s  = 1'b0;
      rd_value_s  = {XLEN{1'b0}};
    end
  end

  // State, op latches and registered outputs; reset abandons any op in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= IDLE;
      funct3_r       <= 3'b000;
      addr_r         <= {ADDR_W{1'b0}};
      src_r          <= {XLEN{1'b0}};
      old_r          <= {XLEN{1'b0}};
      rd_is_x0_r     <= 1'b0;
      need_write_r   <= 1'b0;
      exc_r          <= 1'b0;
      op_ready       <= 1'b1;
      busy           <= 1'b0;
      read_csr       <= 1'b0;
      write_csr      <= 1'b0;
      done           <= 1'b0;
      csr_num        <= {ADDR_W{1'b0}};
      write_function <= 3'b000;
      write_value    <= {XLEN{1'b0}};
      rd_write       <= 1'b0;
      rd_value       <= {XLEN{1'b0}};
      exception      <= 1'b0;
    end else begin
      state_r        <= state_s;
      funct3_r       <= funct3_s;
      addr_r         <= addr_s;
      src_r          <= src_s;
      old_r          <= old_s;
      rd_is_x0_r     <= rd_is_x0_s;
      need_write_r   <= need_write_s;
      exc_r          <= exc_s;
      op_ready       <= op_ready_s;
      busy           <= busy_s;
      read_csr       <= read_csr_s;
      write_csr      <= write_csr_s;
      done           <= done_s;
      csr_num        <= csr_num_s;
      write_function <= write_function_s;
      write_value    <= write_value_s;
      rd_write       <= rd_write_s;
      rd_value       <= rd_value_s;
      exception      <= exception_s;
    end
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Scoreboard bench for csr_access_unit: driver pushes expected responses/writes, monitor checks on done/write_csr.
module tb_csr_access_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  op_funct3 = 3'b000;
  logic [11:0] op_csr_addr = 12'h000;
  logic [31:0] op_rs1_value = 32'h0;
  logic [4:0]  op_zimm = 5'h0;
  logic        op_rs1_is_x0 = 1'b0;
  logic        op_rd_is_x0 = 1'b0;
  logic [11:0] csr_num;
  logic        read_csr;
  logic [31:0] read_value;
  logic        write_csr;
  logic [2:0]  write_function;
  logic [31:0] write_value;
  logic        illegal_instr_exception;
  logic        busy;
  logic        done;
  logic        rd_write;
  logic [31:0] rd_value;
  logic        exception;

  logic [31:0] file_rdata = 32'h0;
  logic        file_exc_rd = 1'b0;
  logic        file_exc_wr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        rd_write;
    logic [31:0] rd_value;
    logic        exception;
  } resp_t;

  resp_t       resp_q[$];
  logic [31:0] wval_q[$];
  logic [2:0]  wfn_q[$];

  assign read_value = read_csr ? file_rdata : 32'hDEAD_BEEF;
  assign illegal_instr_exception = (read_csr & file_exc_rd) | (write_csr & file_exc_wr);

  csr_access_unit #(.XLEN(32), .ADDR_W(12)) dut (
    .clock(clock), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_funct3(op_funct3),
    .op_csr_addr(op_csr_addr), .op_rs1_value(op_rs1_value), .op_zimm(op_zimm),
    .op_rs1_is_x0(op_rs1_is_x0), .op_rd_is_x0(op_rd_is_x0),
    .csr_num(csr_num), .read_csr(read_csr), .read_value(read_value),
    .write_csr(write_csr), .write_function(write_function), .write_value(write_value),
    .illegal_instr_exception(illegal_instr_exception),
    .busy(busy), .done(done), .rd_write(rd_write), .rd_value(rd_value), .exception(exception)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare responses and write beats against the scoreboard queues.
  always @(negedge clock) begin
    if (!reset) begin
      if (done) begin
        if (resp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          resp_t r;
          r = resp_q.pop_front();
          check("rd_write", {31'd0, rd_write}, {31'd0, r.rd_write});
          check("rd_value", rd_value, r.rd_value);
          check("exception", {31'd0, exception}, {31'd0, r.exception});
        end
      end
      if (write_csr) begin
        if (wval_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          check("write_value", write_value, wval_q.pop_front());
          check("write_function", {29'd0, write_function}, {29'd0, wfn_q.pop_front()});
        end
      end
      if (read_csr || write_csr) begin
        check("strobe_overlap", {31'd0, read_csr & write_csr}, 32'd0);
      end
    end
  end

  task automatic do_op(input string name, input logic [2:0] f3, input logic [11:0] addr,
                       input logic [31:0] rs1, input logic [4:0] zimm,
                       input logic rs1x0, input logic rdx0, input logic [31:0] rdata,
                       input logic exr, input logic exw,
                       input int exp_lat, input int exp_reads, input int exp_writes,
                       input logic [31:0] exp_wval, input logic exp_rdw,
                       input logic [31:0] exp_rdv, input logic exp_exc);
    resp_t r;
    int cycles;
    int reads;
    int writes;
    bit got;
    r.rd_write  = exp_rdw;
    r.rd_value  = exp_rdv;
    r.exception = exp_exc;
    resp_q.push_back(r);
    if (exp_writes > 0) begin
      wval_q.push_back(exp_wval);
      wfn_q.push_back(f3);
    end
    @(negedge clock);
    file_rdata   = rdata;
    file_exc_rd  = exr;
    file_exc_wr  = exw;
    op_funct3    = f3;
    op_csr_addr  = addr;
    op_rs1_value = rs1;
    op_zimm      = zimm;
    op_rs1_is_x0 = rs1x0;
    op_rd_is_x0  = rdx0;
    op_valid     = 1'b1;
    check({name, "_ready"}, {31'd0, op_ready}, 32'd1);
    @(posedge clock);
    cycles = 0; reads = 0; writes = 0; got = 1'b0;
    // op_valid stays high while busy; the unit must ignore it
    while (!got && cycles < 10) begin
      @(negedge clock);
      cycles++;
      if (read_csr) reads++;
      if (write_csr) writes++;
      if (read_csr || write_csr) check({name, "_csr_num"}, {20'd0, csr_num}, {20'd0, addr});
      if (done) got = 1'b1;
    end
    op_valid = 1'b0;
    check({name, "_latency"}, cycles, exp_lat);
    check({name, "_reads"}, reads, exp_reads);
    check({name, "_writes"}, writes, exp_writes);
    @(negedge clock);
    check({name, "_idle_ready"}, {31'd0, op_ready}, 32'd1);
    check({name, "_idle_done"}, {31'd0, done}, 32'd0);
    file_exc_rd = 1'b0;
    file_exc_wr = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_ready", {31'd0, op_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_strobes", {30'd0, read_csr, write_csr}, 32'd0);
    check("rst_csr_num", {20'd0, csr_num}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_ready", {31'd0, op_ready}, 32'd1);

    //    name       f3      addr     rs1            zimm   rs1x0 rdx0 rdata          exr   exw   lat r w  wval           rdw   rdv            exc
    do_op("csrrs_ro", 3'b010, 12'hC00, 32'h0,         5'h0,  1'b1, 1'b0, 32'h0000_1234, 1'b0, 1'b0, 2, 1, 0, 32'h0,         1'b1, 32'h0000_1234, 1'b0);
    do_op("csrrc",    3'b011, 12'h340, 32'h0000_000F, 5'h0,  1'b0, 1'b0, 32'hFFFF_00FF, 1'b0, 1'b0, 3, 1, 1, 32'hFFFF_00F0, 1'b1, 32'hFFFF_00FF, 1'b0);
    do_op("csrrwi",   3'b101, 12'h305, 32'hFFFF_FFFF, 5'h1F, 1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 2, 0, 1, 32'h0000_001F, 1'b0, 32'h0,         1'b0);
    do_op("csrrs",    3'b010, 12'h300, 32'h0000_0808, 5'h0,  1'b0, 1'b0, 32'h1800_0000, 1'b0, 1'b0, 3, 1, 1, 32'h1800_0808, 1'b1, 32'h1800_0000, 1'b0);
    do_op("csrrsi",   3'b110, 12'h344, 32'hFFFF_FFFF, 5'h0A, 1'b0, 1'b1, 32'h0000_0101, 1'b0, 1'b0, 3, 1, 1, 32'h0000_010B, 1'b0, 32'h0000_0101, 1'b0);
    do_op("rd_exc",   3'b001, 12'h7C0, 32'h0000_00AA, 5'h0,  1'b0, 1'b0, 32'h0000_0055, 1'b1, 1'b0, 2, 1, 0, 32'h0,         1'b0, 32'h0000_0055, 1'b1);
    do_op("f3_100",   3'b100, 12'h300, 32'h0000_0001, 5'h1,  1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1, 0, 0, 32'h0,         1'b0, 32'h0,         1'b1);
    do_op("f3_000",   3'b000, 12'h305, 32'h0000_0001, 5'h1,  1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 1, 0, 0, 32'h0,         1'b0, 32'h0,         1'b1);
`ifdef CSR_ACCESS_RO_CHECK_EN
    do_op("ro_write", 3'b001, 12'hC01, 32'h0000_AAAA, 5'h0,  1'b0, 1'b1, 32'h0,         1'b0, 1'b1, 1, 0, 0, 32'h0,         1'b0, 32'h0,         1'b1);
    do_op("ro_rci",   3'b111, 12'hC02, 32'h0,         5'h03, 1'b0, 1'b0, 32'h0000_000F, 1'b0, 1'b0, 2, 1, 0, 32'h0,         1'b0, 32'h0000_000F, 1'b1);
`else
    do_op("ro_write", 3'b001, 12'hC01, 32'h0000_AAAA, 5'h0,  1'b0, 1'b1, 32'h0,         1'b0, 1'b1, 2, 0, 1, 32'h0000_AAAA, 1'b0, 32'h0,         1'b1);
    do_op("ro_rci",   3'b111, 12'hC02, 32'h0,         5'h03, 1'b0, 1'b0, 32'h0000_000F, 1'b0, 1'b0, 3, 1, 1, 32'h0000_000C, 1'b1, 32'h0000_000F, 1'b0);
`endif

    // Reset during READ abandons the op: no done, back to idle.
    @(negedge clock);
    op_funct3 = 3'b010; op_csr_addr = 12'h300; op_rs1_value = 32'h0000_0001;
    op_rs1_is_x0 = 1'b0; op_rd_is_x0 = 1'b0; file_rdata = 32'h0000_00F0;
    op_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    op_valid = 1'b0;
    check("mid_read_strobe", {31'd0, read_csr}, 32'd1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_strobes", {30'd0, read_csr, write_csr}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ready", {31'd0, op_ready}, 32'd1);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("after_rst_done", {31'd0, done}, 32'd0);
    end
    check("after_rst_ready", {31'd0, op_ready}, 32'd1);

    check("resp_q_empty", resp_q.size(), 32'd0);
    check("wval_q_empty", wval_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
